ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain PS/2 clock/data pair.
- Counterpart to the keyboard receive path in the KEYBOARD block.
- Handles the inhibit / request-to-send sequence, shifts out data bits, parity and stop bit on device-generated clocks, checks the device ACK, and reports done or error to the controlling logic.

---
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shift an
// 11-bit frame out on device-generated clocks and check the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   frame_q, frame_d;
    logic [3:0]    edge_cnt_q, edge_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          clk_drv_q, clk_drv_d;
    logic          data_drv_q, data_drv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic          ps2_clk_s, ps2_data_s, ps2_fall;

    assign ps2_clk_s  = clk_sync_q[1];
    assign ps2_data_s = data_sync_q[1];
    assign ps2_fall   = clk_prev_q & ~ps2_clk_s;

    // Sync flops reset to 1 (idle bus) so reset release never looks like an edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= ps2_clk_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        edge_cnt_d = edge_cnt_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                edge_cnt_d = '0;
                if (tx_req) begin
                    frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = RTS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RTS: begin
                cnt_d      = '0;
                edge_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (ps2_fall) begin
                    cnt_d      = '0;
                    frame_d    = {1'b1, frame_q[10:1]};
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q == 4'd9) state_d = ACK;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACK: begin
                if (ps2_fall) begin
                    cnt_d = '0;
                    if (!ps2_data_s) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (cnt_q >= TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_IDLE: begin
                if (ps2_clk_s && ps2_data_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (ps2_fall) begin
                    cnt_d = '0;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pad drives are registered from the next state so they never glitch.
        clk_drv_d  = (state_d == INHIBIT);
        data_drv_d = ((state_d == RTS) || (state_d == SEND)) && !frame_d[0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            frame_q    <= '1;
            edge_cnt_q <= '0;
            cnt_q      <= '0;
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            edge_cnt_q <= edge_cnt_d;
            cnt_q      <= cnt_d;
            clk_drv_q  <= clk_drv_d;
            data_drv_q <= data_drv_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ps2_clk_drive_low  = clk_drv_q;
    assign ps2_data_drive_low = data_drv_q;
    assign busy               = (state_q != IDLE);
    assign tx_done            = done_q;
    assign tx_error           = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out
// of the host, and each scenario checks frame bits, pulses and bus release.
module tb_ps2_host_tx;

    localparam int INH = 200;
    localparam int TO  = 1000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error;
    logic       clk_line, data_line;

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_run = 0, last_inh = 0, inh_starts = 0;

    assign clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
    assign data_line = ~(ps2_data_drive_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetN(resetN), .tx_req(tx_req), .tx_data(tx_data),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
        .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
        if (ps2_clk_drive_low) begin
            if (inh_run == 0) inh_starts++;
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [7:0] d);
        tx_data = d;
        tx_req  = 1'b1;
        tick();
        tx_req  = 1'b0;
    endtask

    task automatic wait_pulse();
        int w = 0;
        int s = done_cnt + err_cnt;
        while ((done_cnt + err_cnt) == s && w < 20) begin tick(); w++; end
        tick(2);
    endtask

    // Device: waits for request-to-send, then generates 11 clock pulses,
    // sampling the line mid-low after edges 1..10 (data0..7, parity, stop).
    task automatic dev_frame(input bit ack, input int abort_at,
                             output logic [9:0] got, output bit ok);
        int w = 0;
        got = '0;
        ok  = 1'b0;
        while (!(ps2_clk_drive_low == 1'b0 && ps2_data_drive_low == 1'b1) && w < INH + 100) begin
            tick(); w++;
        end
        if (w >= INH + 100) return;
        ok = (clk_line === 1'b1) && (data_line === 1'b0);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            tick(H);
            dev_clk_low = 1'b1;
            if (k == abort_at) begin tick(H / 2); return; end
            tick(H);
            if (k <= 10) got[k-1] = data_line;
            dev_clk_low = 1'b0;
            if (k == 11) dev_data_low = 1'b0;
            else tick(H);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick(2);
        n_cmp++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done, tx_error});
        end
        resetN = 1'b1;
        tick(3);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_send_ed();
        logic [9:0] got; bit ok;
        int d0 = done_cnt, e0 = err_cnt;
        last_inh = 0;
        send_req(8'hED);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL ed_busy_rise: got %b want 1", busy); end
        dev_frame(1'b1, 0, got, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL ed_start_bit: got %b want 1", ok); end
        n_cmp++;
        if (last_inh !== INH) begin n_bad++; $display("FAIL ed_inhibit_len: got %0d want %0d", last_inh, INH); end
        n_cmp++;
        if (got !== 10'b1_1_11101101) begin n_bad++; $display("FAIL ed_frame: got %b want 1111101101", got); end
        wait_pulse();
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_bad++; $display("FAIL ed_pulses: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
        n_cmp++;
        if ({busy, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b000) begin
            n_bad++; $display("FAIL ed_idle_after: got %b want 000", {busy, ps2_clk_drive_low, ps2_data_drive_low});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got; bit ok;
        int w = 0;
        int d0 = done_cnt;
        send_req(8'h00);
        tx_data = 8'h01;
        tx_req  = 1'b1;
        dev_frame(1'b1, 0, got, ok);
        n_cmp++;
        if (got !== 10'b1_1_00000000) begin n_bad++; $display("FAIL b2b_frame00: got %b want 1100000000", got); end
        while (tx_done !== 1'b1 && w < 20) begin tick(); w++; end
        n_cmp++;
        if (tx_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_first_done: done %b busy %b want 1 0", tx_done, busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
        tx_req = 1'b0;
        dev_frame(1'b1, 0, got, ok);
        n_cmp++;
        if (got !== 10'b1_0_00000001) begin n_bad++; $display("FAIL b2b_frame01: got %b want 1000000001", got); end
        wait_pulse();
        n_cmp++;
        if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_no_ack();
        logic [9:0] got; bit ok;
        int d0 = done_cnt, e0 = err_cnt;
        send_req(8'hA5);
        dev_frame(1'b0, 0, got, ok);
        wait_pulse();
        tick(10);
        n_cmp++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            n_bad++; $display("FAIL noack_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        n_cmp++;
        if ({busy, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b000) begin
            n_bad++; $display("FAIL noack_idle: got %b want 000", {busy, ps2_clk_drive_low, ps2_data_drive_low});
        end
    endtask

    task automatic test_timeout();
        int w = 0, n = 0;
        int d0 = done_cnt;
        send_req(8'h3C);
        while (!(ps2_data_drive_low && !ps2_clk_drive_low) && w < INH + 100) begin tick(); w++; end
        while (tx_error !== 1'b1 && n < TO + 50) begin tick(); n++; end
        n_cmp++;
        if (n !== TO + 1) begin n_bad++; $display("FAIL timeout_gap: got %0d want %0d", n, TO + 1); end
        n_cmp++;
        if ({busy, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b000) begin
            n_bad++; $display("FAIL timeout_release: got %b want 000", {busy, ps2_clk_drive_low, ps2_data_drive_low});
        end
        tick(5);
        n_cmp++;
        if (done_cnt !== d0) begin n_bad++; $display("FAIL timeout_no_done: got %0d want %0d", done_cnt, d0); end
    endtask

    task automatic test_req_spam();
        logic [9:0] got; bit ok;
        int w = 0;
        int d0 = done_cnt, i0 = inh_starts;
        tx_data = 8'hFF;
        tx_req  = 1'b1;
        tick();
        dev_frame(1'b1, 0, got, ok);
        while (tx_done !== 1'b1 && w < 20) begin tick(); w++; end
        tx_req = 1'b0;
        tick(10);
        n_cmp++;
        if (got !== 10'b1_1_11111111) begin n_bad++; $display("FAIL spam_frame: got %b want 1111111111", got); end
        n_cmp++;
        if (inh_starts - i0 !== 1 || done_cnt - d0 !== 1) begin
            n_bad++; $display("FAIL spam_single: frames %0d done %0d want 1 1", inh_starts - i0, done_cnt - d0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL spam_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got; bit ok;
        int d0 = done_cnt, e0 = err_cnt;
        send_req(8'h2C);
        dev_frame(1'b1, 5, got, ok);
        n_cmp++;
        if ({busy, ps2_data_drive_low} !== 2'b11) begin
            n_bad++; $display("FAIL mid_bit4_drive: got %b want 11", {busy, ps2_data_drive_low});
        end
        #2 resetN = 1'b0;
        #1;
        n_cmp++;
        if ({busy, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b000) begin
            n_bad++; $display("FAIL mid_async_release: got %b want 000", {busy, ps2_clk_drive_low, ps2_data_drive_low});
        end
        dev_clk_low = 1'b0;
        tick(3);
        resetN = 1'b1;
        tick(20);
        n_cmp++;
        if (done_cnt !== d0 || err_cnt !== e0) begin
            n_bad++; $display("FAIL mid_no_pulse: done %0d err %0d want %0d %0d", done_cnt, err_cnt, d0, e0);
        end
        send_req(8'hF4);
        dev_frame(1'b1, 0, got, ok);
        n_cmp++;
        if (got !== 10'b1_0_11110100) begin n_bad++; $display("FAIL mid_f4_frame: got %b want 1011110100", got); end
        wait_pulse();
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
            n_bad++; $display("FAIL mid_f4_done: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_no_ack();
        test_timeout();
        test_req_spam();
        test_reset_mid();
        n_cmp++;
        if (both_cnt !== 0) begin n_bad++; $display("FAIL done_error_overlap: got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
